gpio_debounce: RTL and testbench
================================

Name: gpio_debounce

Overview:
Per-pin input conditioning stage placed between the GPIO pads and gpio_module.val_i.
- Synchronises each asynchronous pad input into the clk domain with a two-flop synchroniser.
- Filters glitches with a per-pin stability counter.
- Presents the debounced level to the GPIO register block, so edge interrupts fire once per real transition.
- Emits a one-cycle change strobe per pin for optional event logging.

Parameters:
N_GPIOS, 8, number of pins handled; must equal the gpio_module N_GPIOS.
DEBOUNCE_CYCLES, 16, consecutive cycles a new synchronised level must persist before val_o adopts it; legal range >= 1.
CNT_W (localparam), $clog2(DEBOUNCE_CYCLES+1), counter width; not user-overridable.

Ports:
clk       input   1         system clock; all state on rising edge
rstn_i    input   1         asynchronous active-low reset
pad_i     input   N_GPIOS   raw asynchronous pad levels
bypass_i  input   N_GPIOS   per-pin: 1 = skip debounce (sync only); quasi-static, from config
val_o     output  N_GPIOS   debounced level, connects to gpio_module val_i
chg_o     output  N_GPIOS   1-cycle pulse, bit i set in the cycle after val_o[i] changed

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rstn_i): it asserts asynchronously, and release is observed on the next clk edge.
- Reset values: sync1, sync2, val_o, chg_o and all counters are 0.
- Synchroniser, per pin i:
  - sync1[i] <= pad_i[i]
  - sync2[i] <= sync1[i]
  - No other logic reads sync1.
- Debounce mode, bypass_i[i] = 0. Evaluated every edge:
  - If sync2[i] == val_o[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: val_o[i] <= sync2[i]; cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: a new pad level first sampled at edge 0 and held appears on val_o at edge DEBOUNCE_CYCLES+1.
- Glitch rule: any single cycle with sync2 == val_o before the terminal count clears cnt. The next mismatch then restarts from 0. Counts are not accumulated across glitches.
- Bypass mode, bypass_i[i] = 1:
  - val_o[i] <= sync2[i] every edge, giving latency of 2 edges.
  - cnt[i] is held at 0.
- Bypass transitions:
  - 1->0: counting starts from 0 on the next mismatch.
  - 0->1 mid-count: the partial count is discarded, and val_o follows sync2 from the next edge.
- chg_o[i] <= (next val_o[i] != val_o[i]), in both modes.
  - chg_o is a registered pulse, high for exactly one cycle per val_o transition.
  - Back-to-back transitions in bypass mode give consecutive pulses.
- Pin independence: no cross-pin interaction; all N_GPIOS pins may switch on the same edge.
- Counter width: no overflow is possible, because cnt is reset on reaching DEBOUNCE_CYCLES-1.
  - DEBOUNCE_CYCLES = 1 degenerates to "adopt on first mismatch edge" (edge 2 after sampling).
- Reset mid-count: all state returns to 0 immediately.
  - A pad held at 1 through reset release is treated as a fresh 0->1 transition: val_o rises DEBOUNCE_CYCLES+1 edges after the first sampling edge.
- No combinational path from any input to any output.

Test Plan:
1. Reset. pad_i = 8'hFF and bypass_i = 0 during reset, rstn_i released before edge 0 (DEBOUNCE_CYCLES = 4) -> val_o = 0 and chg_o = 0 through edge 4. val_o = 8'hFF from edge 5, with chg_o = 8'hFF for exactly one cycle.
2. Clean step, DEBOUNCE_CYCLES = 4. pad_i[0] 0->1 sampled at edge 0 -> val_o[0] = 1 after edge 5, chg_o[0] high only for the cycle following edge 5. Other bits stay 0.
3. Glitch rejection. pad_i[3] high for 3 cycles, low for 1, then high again -> val_o[3] rises only after 4 consecutive high synchronised cycles following the glitch. No chg_o pulse from the short pulse.
4. Bypass. bypass_i[5] = 1 and pad_i[5] toggles every 2 cycles -> val_o[5] mirrors pad_i[5] delayed 2 edges, with a chg_o[5] pulse on each transition.
5. Bypass switch mid-count. Set bypass_i[2] = 1 at count 2 of a pending change -> val_o[2] updates on the next edge. Clear bypass_i[2] and apply a new change -> a full 4-cycle count is required.
6. Multi-pin simultaneity. pad_i 8'h00->8'hA5 on one edge -> val_o = 8'hA5 at edge 5, with chg_o = 8'hA5 for a single cycle.

Source files
------------

// File: rtl/gpio_debounce.sv
// Per-pin pad conditioning: two-flop synchroniser, stability-count debounce,
// optional per-pin bypass, and a registered one-cycle change strobe.

module gpio_debounce_pin #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic pad,
    input  logic bypass,
    output logic val,
    output logic chg
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             val_nxt;

    // Any cycle where sync2 agrees with val clears the count, so glitches never accumulate.
    always_comb begin
        val_nxt = val;
        cnt_nxt = '0;
        if (bypass) begin
            val_nxt = sync2;
        end else if (sync2 != val) begin
            if (cnt == CNT_LAST) val_nxt = sync2;
            else                 cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            val   <= 1'b0;
            chg   <= 1'b0;
        end else begin
            sync1 <= pad;
            sync2 <= sync1;
            cnt   <= cnt_nxt;
            val   <= val_nxt;
            chg   <= val_nxt ^ val;
        end
    end
endmodule

module gpio_debounce #(
    parameter int N_GPIOS         = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic [N_GPIOS-1:0] pad_i,
    input  logic [N_GPIOS-1:0] bypass_i,
    output logic [N_GPIOS-1:0] val_o,
    output logic [N_GPIOS-1:0] chg_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < N_GPIOS; i++) begin : g_pin
        gpio_debounce_pin #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_pin (
            .clk   (clk),
            .rstn_i(rstn_i),
            .pad   (pad_i[i]),
            .bypass(bypass_i[i]),
            .val   (val_o[i]),
            .chg   (chg_o[i])
        );
    end
endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce (DEBOUNCE_CYCLES = 4): stimulus pushes
// edge-stamped expectations, a negedge monitor pops and compares them.

module tb_gpio_debounce;
    logic       clk = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] pad_i = 8'h00;
    logic [7:0] bypass_i = 8'h00;
    logic [7:0] val_o, chg_o;

    gpio_debounce #(.N_GPIOS(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rstn_i  (rstn_i),
        .pad_i   (pad_i),
        .bypass_i(bypass_i),
        .val_o   (val_o),
        .chg_o   (chg_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [7:0] mask;
        logic [7:0] val;
        logic [7:0] chg;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   edge_n = -1;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    bit   fin = 1'b0;

    // Edge 0 is the first rising edge with reset released.
    always @(posedge clk) if (rstn_i) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        exp_t x;
        if (!rstn_i) begin
            checks += 1;
            if (val_o !== 8'h00 || chg_o !== 8'h00) begin
                failures += 1;
                $display("FAIL reset_state edge=%0d val_o=%h chg_o=%h expected 00/00", edge_n, val_o, chg_o);
            end
        end else begin
            while (sb.size() > 0 && sb[0].e <= edge_n) begin
                x = sb.pop_front();
                checks += 2;
                if (x.e < edge_n) begin
                    failures += 2;
                    $display("FAIL %s stale_entry edge=%0d at_edge=%0d", x.tag, x.e, edge_n);
                end else begin
                    if ((val_o & x.mask) !== (x.val & x.mask)) begin
                        failures += 1;
                        $display("FAIL %s val edge=%0d mask=%h val_o=%h expected=%h", x.tag, x.e, x.mask, val_o, x.val);
                    end
                    if ((chg_o & x.mask) !== (x.chg & x.mask)) begin
                        failures += 1;
                        $display("FAIL %s chg edge=%0d mask=%h chg_o=%h expected=%h", x.tag, x.e, x.mask, chg_o, x.chg);
                    end
                end
            end
        end
        if (done && !fin) begin
            checks += 1;
            if (sb.size() != 0) begin
                failures += 1;
                $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
            end
            fin = 1'b1;
        end
    end

    task automatic push(input int e, input logic [7:0] m, input logic [7:0] v,
                        input logic [7:0] c, input string tag);
        exp_t x;
        x.e = e; x.mask = m; x.val = v; x.chg = c; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Full-width step: outputs hold prev through s+4, adopt p at s+5.
    task automatic apply(input logic [7:0] p, input logic [7:0] prev, input string tag);
        int s;
        @(negedge clk);
        s = edge_n + 1;
        pad_i = p;
        for (int k = 0; k < 5; k++) push(s + k, 8'hFF, prev, 8'h00, tag);
        push(s + 5, 8'hFF, p, p ^ prev, tag);
        push(s + 6, 8'hFF, p, 8'h00, tag);
        wait_edge(s + 6);
    endtask

    initial begin
        int s, t;
        bit p4[12] = '{1,1,0,0,1,1,0,0,0,0,0,0};
        bit v4[12] = '{0,0,1,1,0,0,1,1,0,0,0,0};
        bit c4[12] = '{0,0,1,0,1,0,1,0,1,0,0,0};

        // 1: pads high through reset release
        pad_i = 8'hFF;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) push(k, 8'hFF, 8'h00, 8'h00, "t1_hold");
        push(5, 8'hFF, 8'hFF, 8'hFF, "t1_rise");
        push(6, 8'hFF, 8'hFF, 8'h00, "t1_pulse_end");
        rstn_i = 1'b1;
        wait_edge(6);
        apply(8'h00, 8'hFF, "t1_clear");

        // 2: clean step on pin 0
        apply(8'h01, 8'h00, "t2_step");

        // 3: glitch on pin 3 (high 3, low 1, high)
        @(negedge clk);
        s = edge_n + 1;
        for (int k = 0; k < 9; k++) push(s + k, 8'h08, 8'h00, 8'h00, "t3_glitch_hold");
        push(s + 9, 8'h08, 8'h08, 8'h08, "t3_rise");
        push(s + 10, 8'h08, 8'h08, 8'h00, "t3_pulse_end");
        pad_i[3] = 1'b1;
        repeat (3) @(negedge clk);
        pad_i[3] = 1'b0;
        @(negedge clk);
        pad_i[3] = 1'b1;
        wait_edge(s + 10);

        // 4: bypass on pin 5, toggling every 2 cycles
        @(negedge clk);
        bypass_i[5] = 1'b1;
        @(negedge clk);
        s = edge_n + 1;
        for (int k = 0; k < 12; k++) begin
            pad_i[5] = p4[k];
            push(s + k, 8'h20, {2'b00, v4[k], 5'b0}, {2'b00, c4[k], 5'b0}, "t4_bypass");
            @(negedge clk);
        end
        bypass_i[5] = 1'b0;

        // 5: bypass asserted at count 2, then cleared for a full count
        @(negedge clk);
        s = edge_n + 1;
        pad_i[2] = 1'b1;
        for (int k = 0; k < 4; k++) push(s + k, 8'h04, 8'h00, 8'h00, "t5_pending");
        push(s + 4, 8'h04, 8'h04, 8'h04, "t5_bypass_take");
        push(s + 5, 8'h04, 8'h04, 8'h00, "t5_pulse_end");
        wait_edge(s + 3);
        bypass_i[2] = 1'b1;
        wait_edge(s + 5);
        bypass_i[2] = 1'b0;
        @(negedge clk);
        t = edge_n + 1;
        pad_i[2] = 1'b0;
        for (int k = 0; k < 5; k++) push(t + k, 8'h04, 8'h04, 8'h00, "t5_full_count");
        push(t + 5, 8'h04, 8'h00, 8'h04, "t5_fall");
        push(t + 6, 8'h04, 8'h00, 8'h00, "t5_pulse_end2");
        wait_edge(t + 6);

        // 6: all pins together
        apply(8'h00, 8'h09, "t6_clear");
        apply(8'hA5, 8'h00, "t6_multi");

        // 7: asynchronous reset in the middle of a pending change
        @(negedge clk);
        pad_i = 8'h5A;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rstn_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s = edge_n + 1;
        for (int k = 0; k < 5; k++) push(s + k, 8'hFF, 8'h00, 8'h00, "t7_after_reset");
        push(s + 5, 8'hFF, 8'h5A, 8'h5A, "t7_rise");
        push(s + 6, 8'hFF, 8'h5A, 8'h00, "t7_pulse_end");
        rstn_i = 1'b1;
        wait_edge(s + 6);

        done = 1'b1;
        wait (fin);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout edge=%0d expected completion", edge_n);
        $fatal(1);
    end
endmodule
